mc_control_fsm: RTL and testbench

Multicycle RV32I control unit for the simpli-v core. Sits upstream of the immediate extender and datapath muxes. Decodes the latched instruction fields (op, funct3, funct7b5) through a per-instruction state sequence. Drives immsrc to the extender, plus all mux selects, write enables and the ALU control code, one state per clock.

---
 rtl/mc_control_fsm_pkg.sv | 65 ++++++
 rtl/mc_control_fsm_alu_decoder.sv | 31 +++
 rtl/mc_control_fsm.sv | 140 ++++++++++++++
 tb/tb_mc_control_fsm.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the simpli-v multicycle control unit.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StJal      = 4'd9,
    StBranch   = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    logic [1:0] sel;
    sel = IMM_I;
    if (op == OP_SW) begin
      sel = IMM_S;
    end else if (op == OP_BR) begin
      sel = IMM_B;
    end else if (op == OP_JAL) begin
      sel = IMM_J;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU decoder: maps aluop and instruction function fields to the ALU control code.
module mc_control_fsm_alu_decoder
  import mc_control_fsm_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type (op[5] set) with funct7b5 is a subtract; addi ignores bit 30.
          3'b000:  alucontrol_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol_o = ALU_SLT;
          3'b110:  alucontrol_o = ALU_OR;
          3'b111:  alucontrol_o = ALU_AND;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM: sequences lw/sw/R/I/beq/bne/jal one state per clock.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  output logic [1:0] immsrc_o,
  output logic [1:0] alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] resultsrc_o,
  output logic       adrsrc_o,
  output logic       irwrite_o,
  output logic       pcwrite_o,
  output logic       regwrite_o,
  output logic       memwrite_o,
  output logic [2:0] alucontrol_o,
  output logic       illegal_op_o
);

  state_e     state_q, state_d;
  logic [1:0] aluop;
  logic       ir_en, pc_update, br_en, rw_en, mw_en, illegal;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = StFetch;
    alusrca_o   = SRCA_PC;
    alusrcb_o   = SRCB_RS2;
    resultsrc_o = RES_ALUOUT;
    adrsrc_o    = 1'b0;
    aluop       = ALUOP_ADD;
    ir_en       = 1'b0;
    pc_update   = 1'b0;
    br_en       = 1'b0;
    rw_en       = 1'b0;
    mw_en       = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      StFetch: begin
        ir_en       = 1'b1;
        alusrcb_o   = SRCB_FOUR;
        resultsrc_o = RES_ALURESULT;
        pc_update   = 1'b1;
        state_d     = StDecode;
      end
      StDecode: begin
        // Precompute the branch target into ALUOut while decoding.
        alusrca_o = SRCA_OLDPC;
        alusrcb_o = SRCB_IMM;
        case (op_i)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_R:         state_d = StExecuteR;
          OP_I:         state_d = StExecuteI;
          OP_JAL:       state_d = StJal;
          OP_BR:        state_d = StBranch;
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alusrca_o = SRCA_RS1;
        alusrcb_o = SRCB_IMM;
        state_d   = (op_i == OP_LW) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        adrsrc_o = 1'b1;
        state_d  = StMemWb;
      end
      StMemWb: begin
        resultsrc_o = RES_DATA;
        rw_en       = 1'b1;
        state_d     = StFetch;
      end
      StMemWrite: begin
        adrsrc_o = 1'b1;
        mw_en    = 1'b1;
        state_d  = StFetch;
      end
      StExecuteR: begin
        alusrca_o = SRCA_RS1;
        aluop     = ALUOP_FUNCT;
        state_d   = StAluWb;
      end
      StExecuteI: begin
        alusrca_o = SRCA_RS1;
        alusrcb_o = SRCB_IMM;
        aluop     = ALUOP_FUNCT;
        state_d   = StAluWb;
      end
      StAluWb: begin
        rw_en   = 1'b1;
        state_d = StFetch;
      end
      StJal: begin
        alusrca_o = SRCA_OLDPC;
        alusrcb_o = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StBranch: begin
        alusrca_o = SRCA_RS1;
        aluop     = ALUOP_SUB;
        br_en     = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  mc_control_fsm_alu_decoder u_alu_decoder (
    .aluop_i      (aluop),
    .funct3_i     (funct3_i),
    .funct7b5_i   (funct7b5_i),
    .op5_i        (op_i[5]),
    .alucontrol_o (alucontrol_o)
  );

  assign immsrc_o = imm_sel(op_i);

  // Enables are gated by reset directly so an in-flight write dies with the reset edge.
  assign irwrite_o    = ir_en & ~reset_i;
  assign pcwrite_o    = (pc_update | (br_en & (zero_i ^ funct3_i[0]))) & ~reset_i;
  assign regwrite_o   = rw_en & ~reset_i;
  assign memwrite_o   = mw_en & ~reset_i;
  assign illegal_op_o = illegal & ~reset_i;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class state by state.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic       adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal_op;
  logic [2:0] alucontrol;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .op_i         (op),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .zero_i       (zero),
    .immsrc_o     (immsrc),
    .alusrca_o    (alusrca),
    .alusrcb_o    (alusrcb),
    .resultsrc_o  (resultsrc),
    .adrsrc_o     (adrsrc),
    .irwrite_o    (irwrite),
    .pcwrite_o    (pcwrite),
    .regwrite_o   (regwrite),
    .memwrite_o   (memwrite),
    .alucontrol_o (alucontrol),
    .illegal_op_o (illegal_op)
  );

  // Vector order: immsrc alusrca alusrcb resultsrc adrsrc irwrite pcwrite regwrite memwrite
  //               alucontrol illegal_op
  function automatic logic [17:0] pack(input logic [1:0] imm, input logic [1:0] asa,
                                       input logic [1:0] asb, input logic [1:0] rs,
                                       input logic ad, input logic ir, input logic pcw,
                                       input logic rw, input logic mw, input logic [2:0] alc,
                                       input logic ill);
    return {imm, asa, asb, rs, ad, ir, pcw, rw, mw, alc, ill};
  endfunction

  task automatic chk(input string tag, input logic [17:0] exp);
    logic [17:0] obs;
    obs = {immsrc, alusrca, alusrcb, resultsrc, adrsrc, irwrite, pcwrite, regwrite, memwrite,
           alucontrol, illegal_op};
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_reset(input string tag, input logic [1:0] imm);
    chk(tag, pack(imm, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 3'b000, 0));
  endtask
  task automatic s_fetch(input string tag, input logic [1:0] imm);
    #1 chk(tag, pack(imm, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 3'b000, 0));
    tick();
  endtask
  task automatic s_decode(input string tag, input logic [1:0] imm, input logic ill);
    #1 chk(tag, pack(imm, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b000, ill));
    tick();
  endtask
  task automatic s_memadr(input string tag, input logic [1:0] imm);
    #1 chk(tag, pack(imm, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0));
    tick();
  endtask
  task automatic s_memread(input string tag);
    #1 chk(tag, pack(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 3'b000, 0));
    tick();
  endtask
  task automatic s_memwb(input string tag);
    #1 chk(tag, pack(2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 1, 0, 3'b000, 0));
    tick();
  endtask
  task automatic s_exec(input string tag, input logic [1:0] imm, input logic [1:0] asb,
                        input logic [2:0] alc);
    #1 chk(tag, pack(imm, 2'b10, asb, 2'b00, 0, 0, 0, 0, 0, alc, 0));
    tick();
  endtask
  task automatic s_aluwb(input string tag, input logic [1:0] imm);
    #1 chk(tag, pack(imm, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 3'b000, 0));
    tick();
  endtask
  task automatic s_branch(input string tag, input logic pcw);
    #1 chk(tag, pack(2'b10, 2'b10, 2'b00, 2'b00, 0, 0, pcw, 0, 0, 3'b001, 0));
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    op       = 7'b0000011;
    funct3   = 3'b010;
    funct7b5 = 1'b0;
    zero     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s_reset("reset_hold", 2'b00);
    reset = 1'b0;

    // lw: 5 cycles
    s_fetch("lw_fetch", 2'b00);
    s_decode("lw_decode", 2'b00, 0);
    s_memadr("lw_memadr", 2'b00);
    s_memread("lw_memread");
    s_memwb("lw_memwb");

    // sw: 4 cycles
    op = 7'b0100011;
    s_fetch("sw_fetch", 2'b01);
    s_decode("sw_decode", 2'b01, 0);
    s_memadr("sw_memadr", 2'b01);
    #1 chk("sw_memwrite", pack(2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 3'b000, 0));
    tick();

    // R-type sub
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    s_fetch("sub_fetch", 2'b00);
    s_decode("sub_decode", 2'b00, 0);
    s_exec("sub_execr", 2'b00, 2'b00, 3'b001);
    s_aluwb("sub_aluwb", 2'b00);

    // R-type slt
    funct3 = 3'b010; funct7b5 = 1'b0;
    s_fetch("slt_fetch", 2'b00);
    s_decode("slt_decode", 2'b00, 0);
    s_exec("slt_execr", 2'b00, 2'b00, 3'b101);
    s_aluwb("slt_aluwb", 2'b00);

    // addi with bit 30 set still adds (op[5] clear)
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    s_fetch("addi_fetch", 2'b00);
    s_decode("addi_decode", 2'b00, 0);
    s_exec("addi_execi", 2'b00, 2'b01, 3'b000);
    s_aluwb("addi_aluwb", 2'b00);

    // ori via I-type
    funct3 = 3'b110; funct7b5 = 1'b0;
    s_fetch("ori_fetch", 2'b00);
    s_decode("ori_decode", 2'b00, 0);
    s_exec("ori_execi", 2'b00, 2'b01, 3'b011);
    s_aluwb("ori_aluwb", 2'b00);

    // beq taken / not taken, bne taken
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    s_fetch("beq_t_fetch", 2'b10);
    s_decode("beq_t_decode", 2'b10, 0);
    s_branch("beq_t_branch", 1'b1);
    zero = 1'b0;
    s_fetch("beq_n_fetch", 2'b10);
    s_decode("beq_n_decode", 2'b10, 0);
    s_branch("beq_n_branch", 1'b0);
    funct3 = 3'b001;
    s_fetch("bne_t_fetch", 2'b10);
    s_decode("bne_t_decode", 2'b10, 0);
    s_branch("bne_t_branch", 1'b1);

    // jal
    op = 7'b1101111; funct3 = 3'b000;
    s_fetch("jal_fetch", 2'b11);
    s_decode("jal_decode", 2'b11, 0);
    #1 chk("jal_jal", pack(2'b11, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 3'b000, 0));
    tick();
    s_aluwb("jal_aluwb", 2'b11);

    // illegal opcode: 2 cycles, pulse only in DECODE
    op = 7'b1111111;
    s_fetch("ill_fetch", 2'b00);
    s_decode("ill_decode", 2'b00, 1);

    // sw aborted by reset in MEMWRITE
    op = 7'b0100011;
    s_fetch("rsw_fetch", 2'b01);
    s_decode("rsw_decode", 2'b01, 0);
    s_memadr("rsw_memadr", 2'b01);
    #1 chk("rsw_memwrite", pack(2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 3'b000, 0));
    #1 reset = 1'b1;
    #1 s_reset("rsw_async", 2'b01);
    tick();
    s_reset("rsw_held", 2'b01);
    reset = 1'b0;
    op = 7'b0000011;
    s_fetch("post_rst_fetch", 2'b00);
    s_decode("post_rst_decode", 2'b00, 0);
    s_memadr("post_rst_memadr", 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
